// File: rtl/mxv_pkg.sv
// rtl/mxv_pkg.sv - shared sizing constants and FSM state type for the mxv sequencer
package mxv_pkg;
  localparam int DATA_W    = 8;
  localparam int MAX_ELEMS = 72;
  localparam int CNT_W     = 7;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    LEAVE,
    CAPTURE,
    PRESENT,
    DONE
  } state_t;
endpackage

// File: rtl/mxv_sequencer.sv
// rtl/mxv_sequencer.sv - fills an external LIFO value buffer with N elements, then streams them back out
module mxv_sequencer #(
  parameter int DATA_W    = mxv_pkg::DATA_W,
  parameter int MAX_ELEMS = mxv_pkg::MAX_ELEMS
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [mxv_pkg::CNT_W-1:0] n_elems,
  input  logic                      abort,
  input  logic                      in_valid,
  input  logic [DATA_W-1:0]         in_data,
  output logic                      in_ready,
  output logic                      buf_load,
  output logic                      buf_leave,
  output logic [DATA_W-1:0]         buf_in,
  input  logic [DATA_W-1:0]         buf_out,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);
  import mxv_pkg::*;

  localparam logic [CNT_W-1:0] MAX_N = CNT_W'(MAX_ELEMS);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  state_t           state, state_next;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] fill_cnt;
  logic             n_ok;

  assign n_ok      = (n_elems != '0) && (n_elems <= MAX_N);
  assign buf_in    = in_data;
  assign buf_load  = in_valid & in_ready;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE) & ~abort;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      remaining <= '0;
      fill_cnt  <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      state <= state_next;
      err   <= 1'b0;
      if (abort) begin
        out_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (n_ok) begin
                remaining <= n_elems;
                fill_cnt  <= '0;
              end else begin
                err <= 1'b1;
              end
            end
          end
          FILL: begin
            if (in_valid) fill_cnt <= fill_cnt + ONE;
          end
          CAPTURE: begin
            out_data  <= buf_out;
            out_valid <= 1'b1;
          end
          PRESENT: begin
            // out_valid is known high throughout PRESENT, so out_ready alone is the handshake
            if (out_ready) begin
              out_valid <= 1'b0;
              remaining <= remaining - ONE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    buf_leave  = 1'b0;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (start && n_ok) state_next = FILL;
        FILL: begin
          in_ready = 1'b1;
          if (in_valid && (fill_cnt + ONE == remaining)) state_next = LEAVE;
        end
        LEAVE: begin
          buf_leave  = 1'b1;
          state_next = CAPTURE;
        end
        CAPTURE: state_next = PRESENT;
        PRESENT: if (out_ready) state_next = (remaining == ONE) ? DONE : LEAVE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mxv_sequencer.sv
// tb/tb_mxv_sequencer.sv - randomized and directed checks of mxv_sequencer against a LIFO transaction model
module tb_mxv_sequencer;
  localparam int CW = mxv_pkg::CNT_W;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] n_elems = '0;
  logic          abort = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = '0;
  logic          in_ready;
  logic          buf_load, buf_leave;
  logic [7:0]    buf_in;
  logic [7:0]    buf_out = '0;
  logic          out_valid;
  logic [7:0]    out_data;
  logic          out_ready = 1'b0;
  logic          busy, done, err;

  mxv_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .n_elems(n_elems), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .buf_load(buf_load), .buf_leave(buf_leave), .buf_in(buf_in), .buf_out(buf_out),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Value buffer: shift-in and shift-out at the low end, registered read port
  logic [7:0] bq[$];
  always @(posedge clk) begin
    if (buf_load) bq.push_front(buf_in);
    if (buf_leave) begin
      if (bq.size() > 0) buf_out <= bq.pop_front();
      else buf_out <= 8'hEE;
    end
  end

  // Transaction model: accepted inputs of the live transaction, replayed newest first
  logic [7:0] acc_q[$];
  logic [7:0] seen_q[$];
  int         seen_cyc[$];
  int         rem_exp = 0;
  bit         model_busy = 0, done_exp = 0, err_exp = 0, abort_prev = 0;
  bit         prev_valid = 0, prev_hs = 0;
  logic [7:0] prev_data = '0;
  int         leave_cyc = 0, n_leave = 0, done_cyc = 0;
  logic [7:0] exp_d;

  always @(negedge clk) begin
    if (!reset) begin
      acc_q.delete();
      rem_exp = 0; model_busy = 0; done_exp = 0; err_exp = 0;
      abort_prev = 0; prev_valid = 0; prev_hs = 0;
    end else begin
      chk("done", done, done_exp);
      chk("err", err, err_exp);
      chk("busy", busy, model_busy);
      chk("strobe_excl", buf_load & buf_leave, 0);
      if (abort_prev) chk("abort_clears_valid", out_valid, 0);
      if (prev_valid && !prev_hs && out_valid) chk("hold_data", out_data, prev_data);
      if (out_valid && !prev_valid) chk("latency", cyc - leave_cyc, 2);
      if (done) done_cyc = cyc;
      if (done_exp) model_busy = 0;
      done_exp = 0;
      err_exp  = 0;
      if (abort) begin
        acc_q.delete();
        rem_exp = 0;
        model_busy = 0;
      end else begin
        if (start && !model_busy) begin
          if (n_elems != 0 && n_elems <= 72) begin
            acc_q.delete();
            rem_exp = int'(n_elems);
            model_busy = 1;
          end else begin
            err_exp = 1;
          end
        end
        if (in_valid && in_ready) begin
          chk("overfill", acc_q.size() < rem_exp, 1);
          acc_q.push_back(in_data);
        end
        if (buf_leave) begin
          leave_cyc = cyc;
          n_leave++;
        end
        if (out_valid && out_ready) begin
          if (acc_q.size() == 0) chk("underflow", out_data, 32'hFFFF);
          else begin
            exp_d = acc_q.pop_back();
            chk("out_data", out_data, exp_d);
          end
          seen_q.push_back(out_data);
          seen_cyc.push_back(cyc);
          rem_exp--;
          if (rem_exp == 0) done_exp = 1;
        end
      end
      abort_prev = abort;
      prev_valid = out_valid;
      prev_hs    = out_valid & out_ready;
      prev_data  = out_data;
    end
  end

  logic [7:0] src[128];

  task automatic run_txn(input int n, input int gap, input int rdy_pct, input int hold, input int abort_at);
    int idx = 0, vcyc = 0, t = 0;
    bit fin = 0;
    @(posedge clk); #1;
    start = 1'b1; n_elems = CW'(n);
    @(posedge clk); #1;
    start = 1'b0;
    while (!fin) begin
      if (abort_at >= 0 && idx == abort_at) begin
        abort = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        abort = 1'b0;
        fin = 1;
      end else begin
        in_valid  = (idx < n) && ($urandom_range(99) >= gap);
        in_data   = src[idx];
        out_ready = (vcyc >= hold) && ($urandom_range(99) < rdy_pct);
        @(negedge clk);
        if (in_valid && in_ready) idx++;
        if (out_valid) vcyc++;
        if (done) fin = 1;
        t++;
        if (t > 4000) begin
          chk("timeout", t, 0);
          fin = 1;
        end
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic bad_start(input int n);
    @(posedge clk); #1;
    start = 1'b1; n_elems = CW'(n);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("err_pulse", err, 1);
    chk("err_busy", busy, 0);
    chk("err_strobes", buf_load | buf_leave, 0);
    @(negedge clk);
    chk("err_one_cycle", err, 0);
  endtask

  task automatic check_all_zero(input string name);
    chk(name, {out_valid, in_ready, buf_load, buf_leave, busy, done, err}, 0);
    chk({name, "_data"}, out_data, 0);
  endtask

  initial begin
    int n, ab;
    #12;
    check_all_zero("reset_state");
    @(posedge clk); #1;
    reset = 1'b1;

    // three elements back-to-back, consumer always ready
    src[0] = 8'h11; src[1] = 8'h22; src[2] = 8'h33;
    seen_q.delete(); seen_cyc.delete();
    run_txn(3, 0, 100, 0, -1);
    chk("n3_count", seen_q.size(), 3);
    if (seen_q.size() == 3) begin
      chk("n3_out0", seen_q[0], 8'h33);
      chk("n3_out1", seen_q[1], 8'h22);
      chk("n3_out2", seen_q[2], 8'h11);
      chk("n3_rate", seen_cyc[1] - seen_cyc[0], 3);
      chk("n3_done_time", done_cyc - seen_cyc[2], 1);
    end

    bad_start(0);
    bad_start(73);

    // start and abort together in IDLE: abort wins
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1; n_elems = CW'(3);
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("abort_beats_start", busy, 0);

    // full buffer with random source gaps
    for (int i = 0; i < 72; i++) src[i] = 8'(i);
    seen_q.delete(); n_leave = 0;
    run_txn(72, 40, 100, 0, -1);
    chk("n72_count", seen_q.size(), 72);
    chk("n72_leaves", n_leave, 72);
    if (seen_q.size() == 72) begin
      chk("n72_first", seen_q[0], 8'h47);
      chk("n72_last", seen_q[71], 8'h00);
    end

    // consumer stalls ten cycles in PRESENT
    src[0] = 8'hC1; src[1] = 8'hC2;
    seen_q.delete(); n_leave = 0;
    run_txn(2, 0, 100, 10, -1);
    chk("stall_leaves", n_leave, 2);
    chk("stall_count", seen_q.size(), 2);

    // abort mid-fill leaves stale bytes that must never surface
    src[0] = 8'hD1; src[1] = 8'hD2; src[2] = 8'hD3; src[3] = 8'hD4;
    run_txn(4, 0, 100, 0, 2);
    src[0] = 8'hA5; src[1] = 8'h5A;
    seen_q.delete();
    run_txn(2, 0, 100, 0, -1);
    chk("abort_count", seen_q.size(), 2);
    if (seen_q.size() == 2) begin
      chk("abort_out0", seen_q[0], 8'h5A);
      chk("abort_out1", seen_q[1], 8'hA5);
    end

    // randomized transactions with gaps, back-pressure and occasional aborts
    for (int k = 0; k < 14; k++) begin
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) src[i] = 8'($urandom);
      ab = ($urandom_range(99) < 20) ? $urandom_range(0, n - 1) : -1;
      run_txn(n, 30, 60, 0, ab);
    end

    // reset while in CAPTURE
    src[0] = 8'h77;
    @(posedge clk); #1;
    start = 1'b1; n_elems = CW'(1);
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; in_data = src[0];
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_reset_leave", buf_leave, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check_all_zero("reset_in_capture");
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("post_reset_busy", busy, 0);
    chk("post_reset_valid", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/mxv_sequencer.md
MXV_SEQUENCER -- requirements
Module: mxv_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, element width in bits.
REQ-002 SHALL have parameter MAX_ELEMS, default 72, buffer depth in elements; CNT_W = 7.
REQ-003 clk  input  1  clock, all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  begin a transaction, sampled in IDLE only.
REQ-006 n_elems  input  CNT_W  element count N for this transaction, sampled with start.
REQ-007 abort  input  1  synchronous cancel, any state.
REQ-008 in_valid / in_data  input  1 / DATA_W  source element stream.
REQ-009 in_ready  output  1  sequencer accepts in_data this cycle.
REQ-010 buf_load / buf_leave  output  1 / 1  shift-in and shift-out strobes to the value buffer.
REQ-011 buf_in  output  DATA_W  element to buffer, equals in_data combinationally.
REQ-012 buf_out  input  DATA_W  buffer read port, valid the cycle after a buf_leave pulse.
REQ-013 out_valid / out_data  output  1 / DATA_W  consumer stream, registered.
REQ-014 out_ready  input  1  consumer accepts out_data.
REQ-015 busy / done / err  output  1 each  not-IDLE level, 1-cycle completion pulse, 1-cycle bad-N pulse.

Function
REQ-016 FSM states SHALL be IDLE, FILL, LEAVE, CAPTURE, PRESENT, DONE.
REQ-017 IDLE: start with 1<=n_elems<=MAX_ELEMS latches N into remaining counter, clears fill counter, moves to FILL.
REQ-018 IDLE: start with n_elems==0 or >MAX_ELEMS pulses err for one cycle and stays IDLE.
REQ-019 start outside IDLE SHALL be ignored.
REQ-020 FILL: in_ready=1; buf_load = in_valid & in_ready (combinational); each accept increments fill counter.
REQ-021 FILL: accept of the Nth element moves to LEAVE on the same edge; in_ready=0 in all other states.
REQ-022 LEAVE: buf_leave=1 for exactly one cycle, then CAPTURE.
REQ-023 CAPTURE: out_data <= buf_out, out_valid <= 1, then PRESENT.
REQ-024 PRESENT: hold out_valid/out_data stable until out_valid & out_ready; on handshake clear out_valid, decrement remaining.
REQ-025 PRESENT handshake: remaining 1->0 goes DONE, otherwise LEAVE.
REQ-026 Output order SHALL be reverse of input order (buffer is LIFO at its low end).
REQ-027 Latency: first out_valid high 2 cycles after LEAVE entry; with out_ready held high, one element per 3 cycles.
REQ-028 DONE: done=1 one cycle, return to IDLE; busy=0 only in IDLE.
REQ-029 buf_load and buf_leave SHALL never be high in the same cycle.
REQ-030 abort SHALL, in any state, force IDLE next edge, clear out_valid, suppress buf_load/buf_leave that cycle, not pulse done.
REQ-031 Abort mid-FILL leaves stale bytes in buffer; subsequent transaction SHALL still return exactly its own N bytes (stale data lies above them).
REQ-032 abort and start in the same IDLE cycle: abort wins, start ignored.

Reset
REQ-033 reset low SHALL asynchronously force IDLE, counters 0, out_data 0, out_valid/in_ready/buf_load/buf_leave/busy/done/err 0.
REQ-034 Reset mid-transaction SHALL discard it; no done pulse after release.

Structure
REQ-035 Shared package mxv_pkg SHALL hold DATA_W, MAX_ELEMS, CNT_W and the state enum type.
REQ-036 Single module, no sub-modules; buffer instantiated alongside by the parent.

Verification
REQ-037 N=3, inputs 0x11,0x22,0x33 back-to-back, out_ready=1 -> outputs 0x33,0x22,0x11, done one cycle after third handshake.
REQ-038 n_elems=0 and n_elems=73 with start -> err one cycle each, busy stays 0, no buf strobes.
REQ-039 N=72 full fill 0x00..0x47 with random in_valid gaps -> 72 outputs 0x47..0x00, no loss.
REQ-040 N=2, out_ready low 10 cycles in PRESENT -> out_data stable, no extra buf_leave.
REQ-041 N=4, abort after 2 accepts, then N=2 with 0xA5,0x5A -> outputs 0x5A,0xA5 only.
REQ-042 reset asserted in CAPTURE -> all outputs 0 immediately, IDLE after release, no done.
